pipelined_control_unit: RTL and testbench

- Next-generation main control for the MIPS datapath.
- Decodes the ID-stage instruction into a 16-bit control word and carries it through ID/EX, EX/MEM and MEM/WB registers.
- Handles external stall/flush by inserting bubbles.
- Runs a HI/LO busy interlock for a multi-cycle multiplier, sized by MULT_LATENCY.
- Adds lw/sw/beq/bne/j decode and defines every control field for every opcode, with no held values.

---
 rtl/ctrl_pkg.sv | 60 ++++++
 rtl/pipelined_control_unit_main_decoder.sv | 128 ++++++++++++
 rtl/pipelined_control_unit.sv | 85 ++++++++
 tb/tb_pipelined_control_unit.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared control-word layout, opcode/funct encodings and the bubble word
// for the pipelined MIPS main control.
package ctrl_pkg;

  localparam int CTRL_W = 16;

  // Control word bit positions
  localparam int B_PCSRC    = 15;
  localparam int B_REGWRITE = 14;
  localparam int B_ALUSRC   = 13;
  localparam int B_REGDST   = 12;
  localparam int B_HIWRITE  = 11;
  localparam int B_LOWRITE  = 10;
  localparam int B_MADD     = 9;
  localparam int B_MSUB     = 8;
  localparam int B_MEMWRITE = 7;
  localparam int B_MEMREAD  = 6;
  localparam int B_BRANCH   = 5;
  localparam int B_MEMTOREG = 4;   // 1 = ALU result, 0 = memory
  localparam int B_HIORLO   = 3;   // 1 = HI, 0 = LO
  localparam int B_HITOREG  = 2;
  localparam int B_DONTMOVE = 1;
  localparam int B_MOVNZ    = 0;

  // Bubble: sequential PC, unconditional (but absent) writeback
  localparam logic [CTRL_W-1:0] CTRL_NOP =
    CTRL_W'(1 << B_PCSRC) | CTRL_W'(1 << B_DONTMOVE);

  // Opcodes
  localparam logic [5:0] OP_SPECIAL  = 6'b000000;
  localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
  localparam logic [5:0] OP_SPECIAL3 = 6'b011111;
  localparam logic [5:0] OP_ADDI     = 6'b001000;
  localparam logic [5:0] OP_ADDIU    = 6'b001001;
  localparam logic [5:0] OP_SLTI     = 6'b001010;
  localparam logic [5:0] OP_SLTIU    = 6'b001011;
  localparam logic [5:0] OP_ANDI     = 6'b001100;
  localparam logic [5:0] OP_ORI      = 6'b001101;
  localparam logic [5:0] OP_XORI     = 6'b001110;
  localparam logic [5:0] OP_LW       = 6'b100011;
  localparam logic [5:0] OP_SW       = 6'b101011;
  localparam logic [5:0] OP_BEQ      = 6'b000100;
  localparam logic [5:0] OP_BNE      = 6'b000101;
  localparam logic [5:0] OP_J        = 6'b000010;

  // Functs
  localparam logic [5:0] FN_MULT    = 6'b011000;
  localparam logic [5:0] FN_MULTU   = 6'b011001;
  localparam logic [5:0] FN_MFHI    = 6'b010000;
  localparam logic [5:0] FN_MFLO    = 6'b010010;
  localparam logic [5:0] FN_MTHI    = 6'b010001;
  localparam logic [5:0] FN_MTLO    = 6'b010011;
  localparam logic [5:0] FN_MOVN    = 6'b001011;
  localparam logic [5:0] FN_MOVZ    = 6'b001010;
  localparam logic [5:0] FN_MUL     = 6'b000010;
  localparam logic [5:0] FN_MADD    = 6'b000000;
  localparam logic [5:0] FN_MSUB    = 6'b000100;
  localparam logic [5:0] FN_SEB_SEH = 6'b100000;

endpackage

// File: rtl/pipelined_control_unit_main_decoder.sv
// Combinational main decoder: instruction -> control word plus HI/LO
// usage flags and an illegal-instruction flag.
module main_decoder (
  input  logic [31:0] instr,
  output logic [15:0] ctrl,
  output logic        hilo_user,
  output logic        mult_class,
  output logic        illegal
);
  import ctrl_pkg::*;

  logic [5:0]        op;
  logic [5:0]        fn;
  logic [CTRL_W-1:0] w;

  assign op = instr[31:26];
  assign fn = instr[5:0];

  // Build the word from an ALU-style base; anything unmatched stays illegal
  always_comb begin
    illegal    = 1'b1;
    hilo_user  = 1'b0;
    mult_class = 1'b0;
    w          = '0;
    w[B_MEMTOREG] = 1'b1;
    w[B_DONTMOVE] = 1'b1;
    case (op)
      OP_SPECIAL: begin
        case (fn)
          6'b100000, 6'b100001, 6'b100010, 6'b100011,
          6'b100100, 6'b100101, 6'b100110, 6'b100111,
          6'b101010, 6'b101011: begin
            illegal = 1'b0;
            w[B_REGWRITE] = 1'b1;
            w[B_REGDST]   = 1'b1;
          end
          FN_MULT, FN_MULTU: begin
            illegal = 1'b0; hilo_user = 1'b1; mult_class = 1'b1;
            w[B_HIWRITE] = 1'b1;
            w[B_LOWRITE] = 1'b1;
          end
          FN_MOVN, FN_MOVZ: begin
            illegal = 1'b0;
            w[B_REGWRITE] = 1'b1;
            w[B_REGDST]   = 1'b1;
            w[B_DONTMOVE] = 1'b0;
            w[B_MOVNZ]    = (fn == FN_MOVN);
          end
          FN_MTHI: begin
            illegal = 1'b0; hilo_user = 1'b1;
            w[B_HIWRITE] = 1'b1;
          end
          FN_MTLO: begin
            illegal = 1'b0; hilo_user = 1'b1;
            w[B_LOWRITE] = 1'b1;
          end
          FN_MFHI, FN_MFLO: begin
            illegal = 1'b0; hilo_user = 1'b1;
            w[B_REGWRITE] = 1'b1;
            w[B_REGDST]   = 1'b1;
            w[B_HITOREG]  = 1'b1;
            w[B_HIORLO]   = (fn == FN_MFHI);
          end
          6'b000000: begin
            // Only the canonical all-zero nop is accepted; other shifts are not decoded
            if (instr == 32'h0) begin
              illegal = 1'b0;
              w       = CTRL_NOP;
            end
          end
          default: ;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
        illegal = 1'b0;
        w[B_REGWRITE] = 1'b1;
        w[B_ALUSRC]   = 1'b1;
      end
      OP_SPECIAL2: begin
        case (fn)
          FN_MUL: begin
            illegal = 1'b0;
            w[B_REGWRITE] = 1'b1;
            w[B_REGDST]   = 1'b1;
          end
          FN_MADD, FN_MSUB: begin
            illegal = 1'b0; hilo_user = 1'b1; mult_class = 1'b1;
            w[B_HIWRITE] = 1'b1;
            w[B_LOWRITE] = 1'b1;
            w[B_MADD]    = (fn == FN_MADD);
            w[B_MSUB]    = (fn == FN_MSUB);
          end
          default: ;
        endcase
      end
      OP_SPECIAL3: begin
        if (fn == FN_SEB_SEH) begin
          illegal = 1'b0;
          w[B_REGWRITE] = 1'b1;
          w[B_REGDST]   = 1'b1;
        end
      end
      OP_LW: begin
        illegal = 1'b0;
        w[B_REGWRITE] = 1'b1;
        w[B_ALUSRC]   = 1'b1;
        w[B_MEMREAD]  = 1'b1;
        w[B_MEMTOREG] = 1'b0;
      end
      OP_SW: begin
        illegal = 1'b0;
        w[B_ALUSRC]   = 1'b1;
        w[B_MEMWRITE] = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        illegal = 1'b0;
        w[B_BRANCH] = 1'b1;
      end
      OP_J: begin
        illegal = 1'b0;
        w       = CTRL_W'(1 << B_PCSRC);
      end
      default: ;
    endcase
    ctrl = illegal ? CTRL_NOP : w;
  end

endmodule

// File: rtl/pipelined_control_unit.sv
// Pipelined MIPS main control: ID decode, ID/EX, EX/MEM, MEM/WB control
// registers, stall/flush bubbling and HI/LO busy interlock.
// Optional macro HILO_INTERLOCK_EN enables the multiplier busy counter;
// without it HiLoStall is 0 and HI/LO ordering is left to software.
module pipelined_control_unit #(
  parameter int MULT_LATENCY = 4,
  parameter int CNT_W        = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] Instruction,
  input  logic        Stall,
  input  logic        Flush,
  output logic [15:0] ExCtrl,
  output logic [15:0] MemCtrl,
  output logic [15:0] WbCtrl,
  output logic        HiLoStall,
  output logic        StallOut,
  output logic        IllegalOp
);
  import ctrl_pkg::*;

  logic [CTRL_W-1:0] dec_ctrl;
  logic              hilo_user;
  logic              mult_class;
  logic              dec_illegal;

  main_decoder u_dec (
    .instr      (Instruction),
    .ctrl       (dec_ctrl),
    .hilo_user  (hilo_user),
    .mult_class (mult_class),
    .illegal    (dec_illegal)
  );

  assign StallOut = Stall | HiLoStall;

`ifdef HILO_INTERLOCK_EN
  logic [CNT_W-1:0] busy_cnt;

  assign HiLoStall = (busy_cnt != '0) && hilo_user;

  // HI/LO busy window: arm when a mult-class op actually enters EX
  always_ff @(posedge Clk) begin
    if (Rst)
      busy_cnt <= '0;
    else if (mult_class && !Flush && !StallOut)
      busy_cnt <= CNT_W'(MULT_LATENCY - 1);
    else if (busy_cnt != '0)
      busy_cnt <= busy_cnt - 1'b1;
  end
`else
  logic unused_hilo;
  localparam int unused_cfg = MULT_LATENCY + CNT_W;

  assign unused_hilo = ^{hilo_user, mult_class};
  assign HiLoStall   = 1'b0;
`endif

  // ID/EX load: reset, then bubble on flush/stall, else the decoded word
  always_ff @(posedge Clk) begin
    if (Rst) begin
      ExCtrl    <= CTRL_NOP;
      IllegalOp <= 1'b0;
    end else if (Flush || StallOut) begin
      ExCtrl    <= CTRL_NOP;
      IllegalOp <= 1'b0;
    end else begin
      ExCtrl    <= dec_ctrl;
      IllegalOp <= dec_illegal;
    end
  end

  // Downstream stages advance every cycle regardless of stall/flush
  always_ff @(posedge Clk) begin
    if (Rst) begin
      MemCtrl <= CTRL_NOP;
      WbCtrl  <= CTRL_NOP;
    end else begin
      MemCtrl <= ExCtrl;
      WbCtrl  <= MemCtrl;
    end
  end

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench for pipelined_control_unit; expectations hand-computed
// for MULT_LATENCY=4, with HILO_INTERLOCK_EN either defined or not.
module tb_pipelined_control_unit;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [31:0] Instruction;
  logic        Stall;
  logic        Flush;
  logic [15:0] ExCtrl;
  logic [15:0] MemCtrl;
  logic [15:0] WbCtrl;
  logic        HiLoStall;
  logic        StallOut;
  logic        IllegalOp;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [15:0] NOP = 16'h8002;

  pipelined_control_unit #(.MULT_LATENCY(4), .CNT_W(4)) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .Instruction (Instruction),
    .Stall       (Stall),
    .Flush       (Flush),
    .ExCtrl      (ExCtrl),
    .MemCtrl     (MemCtrl),
    .WbCtrl      (WbCtrl),
    .HiLoStall   (HiLoStall),
    .StallOut    (StallOut),
    .IllegalOp   (IllegalOp)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [31:0] dec_in  [15];
  logic [15:0] dec_exp [15];

  initial begin
    dec_in[0]  = 32'h21280005; dec_exp[0]  = 16'h6012; // addi
    dec_in[1]  = 32'h8FA80004; dec_exp[1]  = 16'h6042; // lw
    dec_in[2]  = 32'hAFA80004; dec_exp[2]  = 16'h2092; // sw
    dec_in[3]  = 32'h00000000; dec_exp[3]  = 16'h8002; // nop
    dec_in[4]  = 32'h08000010; dec_exp[4]  = 16'h8000; // j
    dec_in[5]  = 32'h11090003; dec_exp[5]  = 16'h0032; // beq
    dec_in[6]  = 32'h15090003; dec_exp[6]  = 16'h0032; // bne
    dec_in[7]  = 32'h0109580B; dec_exp[7]  = 16'h5011; // movn
    dec_in[8]  = 32'h0109580A; dec_exp[8]  = 16'h5010; // movz
    dec_in[9]  = 32'h01095820; dec_exp[9]  = 16'h5012; // add
    dec_in[10] = 32'h71095802; dec_exp[10] = 16'h5012; // mul
    dec_in[11] = 32'h7C095C20; dec_exp[11] = 16'h5012; // seb
    dec_in[12] = 32'h31280005; dec_exp[12] = 16'h6012; // andi
    dec_in[13] = 32'h00005810; dec_exp[13] = 16'h501E; // mfhi
    dec_in[14] = 32'h01000013; dec_exp[14] = 16'h0412; // mtlo

    // Reset
    Rst = 1'b1; Stall = 1'b0; Flush = 1'b0; Instruction = 32'h21280005;
    tick(); tick();
    chk("rst_ex",  ExCtrl,  NOP);
    chk("rst_mem", MemCtrl, NOP);
    chk("rst_wb",  WbCtrl,  NOP);
    chk("rst_hls", HiLoStall, 1'b0);
    chk("rst_ill", IllegalOp, 1'b0);

    // Pipeline latency: addi, lw, sw followed through the stages
    Rst = 1'b0;
    Instruction = 32'h21280005; tick();
    chk("addi_ex", ExCtrl, 16'h6012);
    Instruction = 32'h8FA80004; tick();
    chk("lw_ex", ExCtrl, 16'h6042);
    chk("addi_mem", MemCtrl, 16'h6012);
    Instruction = 32'hAFA80004; tick();
    chk("sw_ex", ExCtrl, 16'h2092);
    chk("lw_mem", MemCtrl, 16'h6042);
    chk("addi_wb", WbCtrl, 16'h6012);

    // Decode table
    for (int i = 0; i < 15; i++) begin
      Instruction = dec_in[i];
      tick();
      chk($sformatf("dec%0d_ex", i), ExCtrl, dec_exp[i]);
      chk($sformatf("dec%0d_ill", i), IllegalOp, 1'b0);
    end

    // madd decodes, then drain any busy window with nops
    Instruction = 32'h71090000; tick();
    chk("madd_ex", ExCtrl, 16'h0E12);
    Instruction = 32'h71090004; tick();
    chk("msub_ex", ExCtrl, `ifdef HILO_INTERLOCK_EN NOP `else 16'h0D12 `endif);
    Instruction = 32'h0; tick(); tick(); tick(); tick(); tick();

    // mult then mflo
    Instruction = 32'h012A0018; tick();
    chk("mult_ex", ExCtrl, 16'h0C12);
    Instruction = 32'h00005812; #1;
`ifdef HILO_INTERLOCK_EN
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("mflo_hls%0d", k), HiLoStall, 1'b1);
      chk($sformatf("mflo_so%0d", k), StallOut, 1'b1);
      tick();
      chk($sformatf("mflo_bub%0d", k), ExCtrl, NOP);
    end
`endif
    chk("mflo_free", HiLoStall, 1'b0);
    chk("mflo_so_free", StallOut, 1'b0);
    tick();
    chk("mflo_ex", ExCtrl, 16'h5016);

    // Flush+Stall kill a mult: it must not arm the busy window
    Instruction = 32'h012A0018; Stall = 1'b1; Flush = 1'b1; #1;
    chk("fs_so", StallOut, 1'b1);
    tick();
    chk("fs_ex", ExCtrl, NOP);
    Stall = 1'b0; Flush = 1'b0; Instruction = 32'h00005812; #1;
    chk("fs_hls", HiLoStall, 1'b0);
    tick();
    chk("fs_mflo_ex", ExCtrl, 16'h5016);

    // Flush alone on a legal op
    Instruction = 32'h21280005; Flush = 1'b1; tick();
    chk("flush_ex", ExCtrl, NOP);
    Flush = 1'b0;

    // Illegal opcode: one-cycle pulse
    Instruction = 32'hFC000000; tick();
    chk("ill_ex", ExCtrl, NOP);
    chk("ill_flag", IllegalOp, 1'b1);
    Instruction = 32'h0; tick();
    chk("ill_clear", IllegalOp, 1'b0);
    Instruction = 32'h0000003F; tick();
    chk("illfn_flag", IllegalOp, 1'b1);
    chk("illfn_ex", ExCtrl, NOP);
    // Stalled illegal never raises the flag
    Instruction = 32'hFC000000; Stall = 1'b1; tick();
    chk("ill_stall_flag", IllegalOp, 1'b0);
    chk("ill_stall_ex", ExCtrl, NOP);
    Stall = 1'b0;

    // Mid-operation reset clears the busy window and all stages
    Instruction = 32'h012A0018; tick();
    chk("mult2_ex", ExCtrl, 16'h0C12);
    Rst = 1'b1; Instruction = 32'h00005812; tick();
    chk("mrst_ex",  ExCtrl,  NOP);
    chk("mrst_mem", MemCtrl, NOP);
    chk("mrst_wb",  WbCtrl,  NOP);
    chk("mrst_hls", HiLoStall, 1'b0);
    Rst = 1'b0; tick();
    chk("mrst_mflo_ex", ExCtrl, 16'h5016);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
